// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU run-control sequencer.
// State encoding is common to RTL and benches.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Run-control request/status bundle between board logic
// and the clock-enable sequencer.
interface cpu_clk_ctrl_if #(
  parameter int DIV_WIDTH = 3,
  parameter int CNT_WIDTH = 16
);

  logic                 run_req;
  logic                 step_req;
  logic                 halt_in;
  logic                 halt_clr;
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 cpu_ce;
  logic                 cpu_tick;
  logic                 step_done;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] tick_count;

  modport master (
    output run_req, step_req, halt_in, halt_clr,
    output div_load, div_value,
    input  cpu_ce, cpu_tick, step_done, state, tick_count
  );

  modport slave (
    input  run_req, step_req, halt_in, halt_clr,
    input  div_load, div_value,
    output cpu_ce, cpu_tick, step_done, state, tick_count
  );

endinterface

// File: rtl/cpu_clk_ctrl_clk_divider.sv
// Programmable divider: counts 0..reload while enabled and
// flags terminal count; reload register is load-gated.
module cpu_clk_ctrl_clk_divider #(
  parameter int DIV_WIDTH = 3,
  parameter int DIV_RESET = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_value,
  output logic                 o_tc
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_div_reg;

  assign o_tc = i_enable && (r_div == r_div_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_div_reg <= DIV_WIDTH'(DIV_RESET);
    end else begin
      if (!i_enable || o_tc)
        r_div <= '0;
      else
        r_div <= r_div + 1'b1;
      if (i_load)
        r_div_reg <= i_value;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run-control sequencer: free-run, single-step and halt modes
// producing a registered clock enable for the core.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 3,
  parameter int DIV_RESET = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_clk_ctrl_if.slave  bus
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_ce;
  logic                 r_tick;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_tc;
  logic                 w_en;
  logic                 w_load;
  logic                 w_ce_nxt;
  logic                 w_done_nxt;

  assign w_en   = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_load = bus.div_load && !w_en;

  cpu_clk_ctrl_clk_divider #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (w_en),
    .i_load   (w_load),
    .i_value  (bus.div_value),
    .o_tc     (w_tc)
  );

  // Leaving RUN/STEP swallows any terminal count on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.run_req)
          w_state_nxt = ST_RUN;
        else if (bus.step_req)
          w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (bus.halt_in)
          w_state_nxt = ST_HALTED;
        else if (!bus.run_req)
          w_state_nxt = ST_IDLE;
        else
          w_ce_nxt = w_tc;
      end
      ST_STEP: begin
        if (bus.halt_in) begin
          w_state_nxt = ST_HALTED;
        end else if (w_tc) begin
          w_ce_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (bus.halt_clr)
          w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ce    <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ce    <= w_ce_nxt;
      r_done  <= w_done_nxt;
      if (w_ce_nxt) begin
        r_tick  <= ~r_tick;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.cpu_ce     = r_ce;
  assign bus.cpu_tick   = r_tick;
  assign bus.step_done  = r_done;
  assign bus.state      = r_state;
  assign bus.tick_count = r_count;

endmodule
